// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - default geometry and content/parity helpers for the fixed rom.
// even_par is only referenced by builds with ROM_PARITY_EN defined.
package rom_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int WORD_MAX_W = 64;

  // Word i is the nibble (i+1) mod 16 repeated; callers truncate to their DATA_W.
  function automatic logic [WORD_MAX_W-1:0] rom_word(input int unsigned i);
    logic [3:0] nib;
    logic [WORD_MAX_W-1:0] w;
    nib = 4'(i + 1);
    w = {(WORD_MAX_W / 4){nib}};
    return w;
  endfunction

  function automatic logic even_par(input logic [WORD_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rom_if.sv
// rtl/rom_if.sv - read-port bundle for the rom; data_par exists only with ROM_PARITY_EN.
interface rom_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addres;
  logic              en;
  logic [DATA_W-1:0] data_out;
`ifdef ROM_PARITY_EN
  logic              data_par;

  modport master (output addres, output en, input data_out, input data_par);
  modport slave  (input addres, input en, output data_out, output data_par);
`else
  modport master (output addres, output en, input data_out);
  modport slave  (input addres, input en, output data_out);
`endif
endinterface

// File: rtl/rom_table.sv
// rtl/rom_table.sv - purely combinational address-to-word decode of the fixed rom contents.
module rom_table #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);
  import rom_pkg::*;

  logic [WORD_MAX_W-1:0] full_word;

  always_comb begin
    full_word = rom_word(32'(addr));
  end

  assign word = full_word[DATA_W-1:0];

endmodule

// File: rtl/rom.sv
// rtl/rom.sv - fixed-content rom with enable-gated registered read and async active-low reset.
// Optional ROM_PARITY_EN adds data_par, the even parity of data_out, registered alongside it.
module rom #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addres,
  output logic [DATA_W-1:0] data_out,
  input  logic              en,
  input  logic              rst_n
`ifdef ROM_PARITY_EN
  ,
  output logic              data_par
`endif
);
  import rom_pkg::*;

  logic [DATA_W-1:0] table_word;

  rom_table #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_table (
    .addr(addres),
    .word(table_word)
  );

  // Parity shares the data register's block so both always describe the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
`ifdef ROM_PARITY_EN
      data_par <= 1'b0;
`endif
    end else if (en) begin
      data_out <= table_word;
`ifdef ROM_PARITY_EN
      data_par <= even_par(WORD_MAX_W'(table_word));
`endif
    end
  end

endmodule

// File: tb/tb_rom.sv
// tb/tb_rom.sv - self-checking bench for rom; parity checks compile in with ROM_PARITY_EN.
module tb_rom;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [DATA_W-1:0] exp;
    string             name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];
  logic [DATA_W-1:0] exp_q;

  rom_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .addres(bus.addres),
    .data_out(bus.data_out),
    .en(bus.en),
    .rst_n(rst_n)
`ifdef ROM_PARITY_EN
    ,
    .data_par(bus.data_par)
`endif
  );

  always #5 clk = ~clk;

  // Reference: word a is the nibble (a+1) mod 16 written twice in a byte.
  function automatic logic [DATA_W-1:0] ref_word(input int a);
    int n;
    n = (a + 1) % 16;
    return DATA_W'(n * 17);
  endfunction

  function automatic logic ref_par(input logic [DATA_W-1:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  task automatic check_out(input string name, input logic [DATA_W-1:0] exp);
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL %s: data_out=%h expected=%h", name, bus.data_out, exp);
    end
`ifdef ROM_PARITY_EN
    checks++;
    if (bus.data_par !== ref_par(exp)) begin
      errors++;
      $display("FAIL %s_par: data_par=%b expected=%b", name, bus.data_par, ref_par(exp));
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].addr = 3'(i);
      vecs[i].en   = 1'b1;
      vecs[i].name = $sformatf("sweep%0d", i);
    end
    vecs[0].exp = 8'h11; vecs[1].exp = 8'h22; vecs[2].exp = 8'h33; vecs[3].exp = 8'h44;
    vecs[4].exp = 8'h55; vecs[5].exp = 8'h66; vecs[6].exp = 8'h77; vecs[7].exp = 8'h88;
    vecs[8]  = '{addr: 3'd5, en: 1'b1, exp: 8'h66, name: "hold_load"};
    vecs[9]  = '{addr: 3'd2, en: 1'b0, exp: 8'h66, name: "hold1"};
    vecs[10] = '{addr: 3'd2, en: 1'b0, exp: 8'h66, name: "hold2"};
    vecs[11] = '{addr: 3'd2, en: 1'b0, exp: 8'h66, name: "hold3"};
    vecs[12] = '{addr: 3'd2, en: 1'b1, exp: 8'h33, name: "reenable"};
    vecs[13] = '{addr: 3'd7, en: 1'b1, exp: 8'h88, name: "wrap7"};
    vecs[14] = '{addr: 3'd0, en: 1'b1, exp: 8'h11, name: "wrap0"};
    vecs[15] = '{addr: 3'd6, en: 1'b1, exp: 8'h77, name: "six_ones"};

    // Reset held with en=1: clock edges must not load anything.
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.addres = 3'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("reset_hold", 8'h00);

    rst_n = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    check_out("post_reset_en0", 8'h00);

    foreach (vecs[i]) begin
      bus.addres = vecs[i].addr;
      bus.en = vecs[i].en;
      @(negedge clk);
      check_out(vecs[i].name, vecs[i].exp);
    end

    // Address glitches between edges must not reach the output.
    bus.addres = 3'd7;
    bus.en = 1'b1;
    @(negedge clk);
    check_out("glitch_base", 8'h88);
    #2 bus.addres = 3'd1;
    #1 check_out("glitch_mid", 8'h88);
    bus.addres = 3'd4;
    @(negedge clk);
    check_out("glitch_next", 8'h55);

    // Async reset asserted mid-cycle, right after addres=3 was sampled.
    bus.addres = 3'd3;
    @(posedge clk);
    #1 check_out("pre_async_rst", 8'h44);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst_now", 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_out("async_rst_held", 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("rst_release", 8'h44);

    // Randomised traffic against the reference model.
    exp_q = 8'h44;
    for (int n = 0; n < 300; n++) begin
      int a;
      logic e;
      a = int'($urandom_range(0, 7));
      e = ($urandom_range(0, 3) != 0);
      bus.addres = 3'(a);
      bus.en = e;
      @(negedge clk);
      if (e) exp_q = ref_word(a);
      check_out("random", exp_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
